// File: rtl/leap_frame_parser_pkg.sv
// ----------------------------------------------------------------------------
// leap_frame_parser_pkg
// Shared constants for the Leap frame parser: sync bytes, parser state
// encoding, palm field byte offsets inside the payload, and a little-endian
// 16-bit assembly helper.
// ----------------------------------------------------------------------------
package leap_frame_parser_pkg;

    localparam logic [7:0] LEAP_SYNC0 = 8'hA5;
    localparam logic [7:0] LEAP_SYNC1 = 8'h5A;

    typedef logic [1:0] parser_state_t;

    localparam parser_state_t HUNT0   = 2'd0;
    localparam parser_state_t HUNT1   = 2'd1;
    localparam parser_state_t PAYLOAD = 2'd2;
    localparam parser_state_t CKSUM   = 2'd3;

    // Byte offset of the low byte of each palm coordinate within the payload.
    localparam int unsigned PALM_X_OFS = 0;
    localparam int unsigned PALM_Y_OFS = 2;
    localparam int unsigned PALM_Z_OFS = 4;

    function automatic logic [15:0] le16(input logic [7:0] lo, input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/leap_frame_parser_if.sv
// ----------------------------------------------------------------------------
// leap_frame_parser_if
// Byte stream in / decoded frame out bundle for the Leap frame parser.
//   rx_byte, rx_valid      : received byte and its 1-cycle strobe
//   frame_data             : last good payload, byte k at [8k+7:8k]
//   palm_x/palm_y/palm_z   : signed little-endian palm coordinates
//   frame_valid            : 1-cycle pulse when frame_data/palm_* update
// master: byte source / frame consumer. slave: the parser.
// ----------------------------------------------------------------------------
interface leap_frame_parser_if #(
    parameter int unsigned PAYLOAD_BYTES = 16
);
    logic [7:0]                 rx_byte;
    logic                       rx_valid;
    logic [PAYLOAD_BYTES*8-1:0] frame_data;
    logic signed [15:0]         palm_x;
    logic signed [15:0]         palm_y;
    logic signed [15:0]         palm_z;
    logic                       frame_valid;

    modport master (
        output rx_byte, rx_valid,
        input  frame_data, palm_x, palm_y, palm_z, frame_valid
    );

    modport slave (
        input  rx_byte, rx_valid,
        output frame_data, palm_x, palm_y, palm_z, frame_valid
    );
endinterface

// File: rtl/leap_frame_parser_idle_timer.sv
// ----------------------------------------------------------------------------
// leap_frame_parser_idle_timer
// Idle counter for the inter-byte timeout.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : forces the count to zero (byte seen, or parser idle)
//   i_enable       : counts one idle cycle
//   o_expired      : high in the idle cycle where the count sits at TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module leap_frame_parser_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 40000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_cnt;

    assign o_expired = i_enable & (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_expired) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/leap_frame_parser.sv
// ----------------------------------------------------------------------------
// leap_frame_parser
// Finds frames (A5 5A, PAYLOAD_BYTES payload bytes, 8-bit additive checksum)
// in the received byte stream and publishes good payloads with decoded palm XYZ.
//   i_clk, i_rst_n    : clock, asynchronous active-low reset
//   bus (slave)       : rx_byte/rx_valid in; frame_data, palm_*, frame_valid out
//   o_in_frame        : high while the parser is not hunting for the first sync byte
//   o_cksum_err_cnt   : saturating checksum failure count
//   o_timeout_cnt     : saturating inter-byte timeout count
// ----------------------------------------------------------------------------
module leap_frame_parser
    import leap_frame_parser_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 40000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    leap_frame_parser_if.slave bus,
    output logic               o_in_frame,
    output logic [CNT_W-1:0]   o_cksum_err_cnt,
    output logic [CNT_W-1:0]   o_timeout_cnt
);
    localparam int unsigned IDX_W   = $clog2(PAYLOAD_BYTES);
    localparam int unsigned FRAME_W = PAYLOAD_BYTES * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    parser_state_t      r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [7:0]         r_sum, w_sum_nxt;
    logic [FRAME_W-1:0] r_shadow, w_shadow_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic signed [15:0] r_palm_x, r_palm_y, r_palm_z;
    logic               r_frame_valid;
    logic [CNT_W-1:0]   r_cksum_err, r_timeout;
    logic               w_good, w_bad, w_timeout, w_tmr_clear;

    // The timer only runs while a frame is in progress and no byte arrives,
    // so a byte on the expiry cycle suppresses the timeout.
    assign w_tmr_clear = bus.rx_valid | (r_state == HUNT0);

    leap_frame_parser_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_tmr_clear),
        .i_enable  (~w_tmr_clear),
        .o_expired (w_timeout)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_sum_nxt    = r_sum;
        w_shadow_nxt = r_shadow;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        if (bus.rx_valid) begin
            case (r_state)
                HUNT0: begin
                    if (bus.rx_byte == LEAP_SYNC0) w_state_nxt = HUNT1;
                end
                HUNT1: begin
                    if (bus.rx_byte == LEAP_SYNC1) begin
                        w_state_nxt = PAYLOAD;
                        w_idx_nxt   = '0;
                        w_sum_nxt   = '0;
                    end else if (bus.rx_byte != LEAP_SYNC0) begin
                        // A repeated A5 may still be the real first sync byte.
                        w_state_nxt = HUNT0;
                    end
                end
                PAYLOAD: begin
                    w_shadow_nxt[{r_idx, 3'b000} +: 8] = bus.rx_byte;
                    w_sum_nxt = r_sum + bus.rx_byte;
                    w_idx_nxt = r_idx + 1'b1;
                    if (r_idx == LAST_IDX) w_state_nxt = CKSUM;
                end
                CKSUM: begin
                    w_good      = (bus.rx_byte == r_sum);
                    w_bad       = ~w_good;
                    w_state_nxt = HUNT0;
                end
                default: w_state_nxt = HUNT0;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = HUNT0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= HUNT0;
            r_idx         <= '0;
            r_sum         <= '0;
            r_shadow      <= '0;
            r_frame       <= '0;
            r_palm_x      <= '0;
            r_palm_y      <= '0;
            r_palm_z      <= '0;
            r_frame_valid <= 1'b0;
            r_cksum_err   <= '0;
            r_timeout     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_sum         <= w_sum_nxt;
            r_shadow      <= w_shadow_nxt;
            r_frame_valid <= w_good;
            if (w_good) begin
                r_frame  <= r_shadow;
                r_palm_x <= le16(r_shadow[8*PALM_X_OFS +: 8], r_shadow[8*(PALM_X_OFS+1) +: 8]);
                r_palm_y <= le16(r_shadow[8*PALM_Y_OFS +: 8], r_shadow[8*(PALM_Y_OFS+1) +: 8]);
                r_palm_z <= le16(r_shadow[8*PALM_Z_OFS +: 8], r_shadow[8*(PALM_Z_OFS+1) +: 8]);
            end
            if (w_bad && (r_cksum_err != CNT_MAX)) r_cksum_err <= r_cksum_err + 1'b1;
            if (w_timeout && (r_timeout != CNT_MAX)) r_timeout <= r_timeout + 1'b1;
        end
    end

    assign bus.frame_data   = r_frame;
    assign bus.palm_x       = r_palm_x;
    assign bus.palm_y       = r_palm_y;
    assign bus.palm_z       = r_palm_z;
    assign bus.frame_valid  = r_frame_valid;
    assign o_in_frame       = (r_state != HUNT0);
    assign o_cksum_err_cnt  = r_cksum_err;
    assign o_timeout_cnt    = r_timeout;
endmodule
